dmadd_engine: RTL and testbench

Parametrised successor of the delta-MADD scan unit. Holds a DEPTH-entry delta-encoded array and accepts range-add and write commands over a valid/ready handshake. Runs a one-element-per-cycle scan in one of several modes: find lowest nonzero, find highest nonzero, sum of reconstructed values, and an optional peak search. It sits between the command decoder and the 8-bit output mux of the top level.

---
 rtl/dmadd_engine_if.sv | 29 ++
 rtl/dmadd_engine.sv | 213 +++++++++++++++++++++
 tb/tb_dmadd_engine.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/dmadd_engine_if.sv
// Command/result bundle for dmadd_engine: valid/ready command channel plus
// scan status and result outputs.
interface dmadd_engine_if #(
  parameter int IDX_W  = 4,
  parameter int DATA_W = 4,
  parameter int ACC_W  = 16
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [IDX_W-1:0]  cmd_lo;
  logic [IDX_W-1:0]  cmd_hi;
  logic [DATA_W-1:0] cmd_data;
  logic              busy;
  logic              result_valid;
  logic [ACC_W-1:0]  result;
  logic              result_hit;
  logic              err;

  modport master (
    output cmd_valid, cmd_op, cmd_lo, cmd_hi, cmd_data,
    input  cmd_ready, busy, result_valid, result, result_hit, err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_lo, cmd_hi, cmd_data,
    output cmd_ready, busy, result_valid, result, result_hit, err
  );
endinterface

// File: rtl/dmadd_engine.sv
// Delta-encoded range-add array with a one-element-per-cycle scan unit.
// Define DMADD_PEAK_EN to enable the PEAK scan mode (otherwise mode 11 flags err).
module dmadd_engine #(
  parameter int DEPTH  = 16,
  parameter int IDX_W  = 4,
  parameter int DATA_W = 4,
  parameter int ENT_W  = 8,
  parameter int ACC_W  = 16
) (
  input  logic          clk,
  input  logic          rst,
  dmadd_engine_if.slave bus
);

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_RADD  = 2'b10;
  localparam logic [1:0] OP_SCAN  = 2'b11;

  localparam logic [1:0] M_MIN  = 2'b00;
  localparam logic [1:0] M_MAX  = 2'b01;
  localparam logic [1:0] M_SUM  = 2'b10;
  localparam logic [1:0] M_PEAK = 2'b11;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_SCAN = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

  logic signed [ENT_W-1:0] delta [DEPTH];
  logic [1:0]              state;
  logic [1:0]              mode;
  logic [IDX_W-1:0]        idx;
  logic signed [ACC_W-1:0] v;
  logic signed [ACC_W-1:0] acc;
  logic [ACC_W-1:0]        res_q;
  logic                    hit_q;
  logic                    err_q;

  logic                    accept;
  logic                    scan_err;
  logic                    wr_bad;
  logic                    radd_bad;
  logic [IDX_W-1:0]        hi_next;
  logic signed [ENT_W-1:0] data_ext;
  logic signed [ENT_W-1:0] cur;
  logic signed [ACC_W-1:0] cur_ext;
  logic signed [ACC_W-1:0] v_nx;
  logic signed [ACC_W-1:0] acc_nx;
  logic [ACC_W-1:0]        idx_ext;

  assign accept   = bus.cmd_valid && bus.cmd_ready;
  assign wr_bad   = bus.cmd_lo > LAST;
  assign radd_bad = (bus.cmd_lo > LAST) || (bus.cmd_hi > LAST) || (bus.cmd_hi < bus.cmd_lo);
  assign hi_next  = bus.cmd_hi + 1'b1;
  assign data_ext = {{(ENT_W-DATA_W){1'b0}}, bus.cmd_data};

`ifdef DMADD_PEAK_EN
  assign scan_err = 1'b0;
`else
  assign scan_err = (bus.cmd_data[1:0] == M_PEAK);
`endif

  assign cur     = delta[idx];
  assign cur_ext = {{(ACC_W-ENT_W){cur[ENT_W-1]}}, cur};
  assign v_nx    = v + cur_ext;
  assign acc_nx  = acc + v_nx;
  assign idx_ext = {{(ACC_W-IDX_W){1'b0}}, idx};

  assign bus.busy         = (state == S_SCAN);
  assign bus.cmd_ready    = (state != S_SCAN);
  assign bus.result_valid = (state == S_DONE);
  assign bus.result       = res_q;
  assign bus.result_hit   = hit_q;
  assign bus.err          = err_q;

  // Array updates; hi >= lo is guaranteed on the valid path, so the two RADD
  // writes never target the same entry.
  always_ff @(posedge clk) begin
    if (rst || (accept && bus.cmd_op == OP_CLEAR)) begin
      for (int i = 0; i < DEPTH; i++) delta[i] <= '0;
      err_q <= 1'b0;
    end else if (accept) begin
      case (bus.cmd_op)
        OP_WRITE: begin
          if (wr_bad) err_q <= 1'b1;
          else        delta[bus.cmd_lo] <= data_ext;
        end
        OP_RADD: begin
          if (radd_bad) err_q <= 1'b1;
          else begin
            delta[bus.cmd_lo] <= delta[bus.cmd_lo] + data_ext;
            if (bus.cmd_hi != LAST) delta[hi_next] <= delta[hi_next] - data_ext;
          end
        end
        OP_SCAN: begin
          if (scan_err) err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef DMADD_PEAK_EN
  logic signed [ACC_W-1:0] best;
  logic [IDX_W-1:0]        best_idx;
  logic signed [ACC_W-1:0] peak_max;
  logic [IDX_W-1:0]        peak_idx;
  logic                    peak_new;

  // Strict greater-than keeps the lowest index that reaches the maximum.
  assign peak_new = v_nx > best;
  assign peak_max = peak_new ? v_nx : best;
  assign peak_idx = peak_new ? idx : best_idx;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      mode  <= M_MIN;
      idx   <= '0;
      v     <= '0;
      acc   <= '0;
      res_q <= '0;
      hit_q <= 1'b0;
`ifdef DMADD_PEAK_EN
      best     <= '0;
      best_idx <= '0;
`endif
    end else begin
      case (state)
        S_SCAN: begin
          case (mode)
            M_MIN, M_MAX: begin
              if (cur != '0) begin
                state <= S_DONE;
                res_q <= idx_ext;
                hit_q <= 1'b1;
              end else if (idx == ((mode == M_MIN) ? LAST : '0)) begin
                state <= S_DONE;
                res_q <= '0;
                hit_q <= 1'b0;
              end else if (mode == M_MIN) begin
                idx <= idx + 1'b1;
              end else begin
                idx <= idx - 1'b1;
              end
            end
            M_SUM: begin
              v   <= v_nx;
              acc <= acc_nx;
              if (idx == LAST) begin
                state <= S_DONE;
                res_q <= acc_nx;
                hit_q <= 1'b1;
              end else begin
                idx <= idx + 1'b1;
              end
            end
`ifdef DMADD_PEAK_EN
            M_PEAK: begin
              v <= v_nx;
              if (peak_new) begin
                best     <= v_nx;
                best_idx <= idx;
              end
              if (idx == LAST) begin
                state <= S_DONE;
                if (!peak_max[ACC_W-1] && peak_max != '0) begin
                  res_q <= {peak_max[ACC_W-IDX_W-1:0], peak_idx};
                  hit_q <= 1'b1;
                end else begin
                  res_q <= '0;
                  hit_q <= 1'b0;
                end
              end else begin
                idx <= idx + 1'b1;
              end
            end
`endif
            default: begin
              state <= S_DONE;
              res_q <= '0;
              hit_q <= 1'b0;
            end
          endcase
        end
        default: begin
          state <= S_IDLE;
          if (accept && bus.cmd_op == OP_SCAN) begin
            if (scan_err) begin
              state <= S_DONE;
              res_q <= '0;
              hit_q <= 1'b0;
            end else begin
              state <= S_SCAN;
              mode  <= bus.cmd_data[1:0];
              idx   <= (bus.cmd_data[1:0] == M_MAX) ? LAST : '0;
              v     <= '0;
              acc   <= '0;
`ifdef DMADD_PEAK_EN
              best     <= '0;
              best_idx <= '0;
`endif
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmadd_engine.sv
// Directed, table-driven bench for dmadd_engine with hand-computed expectations.
// Covers both builds: PEAK expectations switch on DMADD_PEAK_EN.
module tb_dmadd_engine;

  localparam int DEPTH    = 16;
  localparam int IDX_W    = 4;
  localparam int DATA_W   = 4;
  localparam int ENT_W    = 8;
  localparam int ACC_W    = 16;
  localparam int MAX_WAIT = 100;

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_RADD  = 2'b10;
  localparam logic [1:0] OP_SCAN  = 2'b11;

  typedef struct {
    logic [1:0]  op;
    logic [3:0]  lo;
    logic [3:0]  hi;
    logic [3:0]  data;
    logic [15:0] exp_res;
    logic        exp_hit;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  localparam int NVEC = 17;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;
  vec_t vecs [NVEC];

  dmadd_engine_if #(.IDX_W(IDX_W), .DATA_W(DATA_W), .ACC_W(ACC_W)) bus ();

  dmadd_engine #(
    .DEPTH(DEPTH), .IDX_W(IDX_W), .DATA_W(DATA_W), .ENT_W(ENT_W), .ACC_W(ACC_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Returns at the falling edge of the cycle right after acceptance.
  task automatic apply_stimulus(input logic [1:0] op, input logic [3:0] lo, input logic [3:0] hi,
                                input logic [3:0] data);
    int waited = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_lo    = lo;
    bus.cmd_hi    = hi;
    bus.cmd_data  = data;
    while (!bus.cmd_ready && waited < MAX_WAIT) begin
      @(negedge clk);
      waited++;
    end
    check_output("cmd_ready", 32'(bus.cmd_ready), 32'd1);
    if (bus.cmd_ready) begin
      @(posedge clk);
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
  endtask

  task automatic do_cmd(input string name, input logic [1:0] op, input logic [3:0] lo,
                        input logic [3:0] hi, input logic [3:0] data, input logic exp_err);
    apply_stimulus(op, lo, hi, data);
    check_output({name, "_err"}, 32'(bus.err), 32'(exp_err));
  endtask

  task automatic do_scan(input string name, input logic [1:0] scan_mode, input logic [15:0] exp_res,
                         input logic exp_hit, input logic exp_err, input int exp_lat);
    int lat = 1;
    apply_stimulus(OP_SCAN, 4'd0, 4'd0, {2'b00, scan_mode});
    while (!bus.result_valid && lat < MAX_WAIT) begin
      @(negedge clk);
      lat++;
    end
    check_output({name, "_lat"}, 32'(lat), 32'(exp_lat));
    check_output({name, "_res"}, 32'(bus.result), 32'(exp_res));
    check_output({name, "_hit"}, 32'(bus.result_hit), 32'(exp_hit));
    check_output({name, "_err"}, 32'(bus.err), 32'(exp_err));
    check_output({name, "_ready_at_done"}, 32'({bus.busy, bus.cmd_ready}), 32'd1);
    @(negedge clk);
    check_output({name, "_pulse_end"}, 32'(bus.result_valid), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit seen_valid;

    vecs[0]  = '{OP_SCAN,  4'd0,  4'd0,  4'd0,  16'd0,  1'b0, 1'b0, 17};
    vecs[1]  = '{OP_RADD,  4'd2,  4'd5,  4'd3,  16'd0,  1'b0, 1'b0, 0};
    vecs[2]  = '{OP_SCAN,  4'd0,  4'd0,  4'd2,  16'd12, 1'b1, 1'b0, 17};
    vecs[3]  = '{OP_SCAN,  4'd0,  4'd0,  4'd0,  16'd2,  1'b1, 1'b0, 4};
    vecs[4]  = '{OP_SCAN,  4'd0,  4'd0,  4'd1,  16'd6,  1'b1, 1'b0, 11};
    vecs[5]  = '{OP_CLEAR, 4'd0,  4'd0,  4'd0,  16'd0,  1'b0, 1'b0, 0};
    vecs[6]  = '{OP_RADD,  4'd10, 4'd15, 4'd15, 16'd0,  1'b0, 1'b0, 0};
    vecs[7]  = '{OP_SCAN,  4'd0,  4'd0,  4'd2,  16'd90, 1'b1, 1'b0, 17};
    vecs[8]  = '{OP_SCAN,  4'd0,  4'd0,  4'd1,  16'd10, 1'b1, 1'b0, 7};
    vecs[9]  = '{OP_RADD,  4'd7,  4'd3,  4'd1,  16'd0,  1'b0, 1'b1, 0};
    vecs[10] = '{OP_SCAN,  4'd0,  4'd0,  4'd2,  16'd90, 1'b1, 1'b1, 17};
    vecs[11] = '{OP_WRITE, 4'd15, 4'd0,  4'd9,  16'd0,  1'b0, 1'b1, 0};
    vecs[12] = '{OP_SCAN,  4'd0,  4'd0,  4'd2,  16'd99, 1'b1, 1'b1, 17};
    vecs[13] = '{OP_SCAN,  4'd0,  4'd0,  4'd1,  16'd15, 1'b1, 1'b1, 2};
    vecs[14] = '{OP_CLEAR, 4'd0,  4'd0,  4'd0,  16'd0,  1'b0, 1'b0, 0};
    vecs[15] = '{OP_SCAN,  4'd0,  4'd0,  4'd2,  16'd0,  1'b1, 1'b0, 17};
`ifdef DMADD_PEAK_EN
    vecs[16] = '{OP_SCAN,  4'd0,  4'd0,  4'd3,  16'd0,  1'b0, 1'b0, 17};
`else
    vecs[16] = '{OP_SCAN,  4'd0,  4'd0,  4'd3,  16'd0,  1'b0, 1'b1, 1};
`endif

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_CLEAR;
    bus.cmd_lo    = '0;
    bus.cmd_hi    = '0;
    bus.cmd_data  = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    check_output("reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check_output("reset_busy", 32'(bus.busy), 32'd0);
    check_output("reset_result_valid", 32'(bus.result_valid), 32'd0);
    check_output("reset_result", 32'(bus.result), 32'd0);
    check_output("reset_result_hit", 32'(bus.result_hit), 32'd0);
    check_output("reset_err", 32'(bus.err), 32'd0);

    for (int i = 0; i < NVEC; i++) begin
      if (vecs[i].exp_lat == 0)
        do_cmd($sformatf("vec%0d", i), vecs[i].op, vecs[i].lo, vecs[i].hi, vecs[i].data, vecs[i].exp_err);
      else
        do_scan($sformatf("vec%0d", i), vecs[i].data[1:0], vecs[i].exp_res, vecs[i].exp_hit,
                vecs[i].exp_err, vecs[i].exp_lat);
    end

    // 18 x 15 = 270 wraps delta[0] to 14 and delta[1] to -14.
    do_cmd("wrap_clear", OP_CLEAR, 4'd0, 4'd0, 4'd0, 1'b0);
    for (int i = 0; i < 18; i++) apply_stimulus(OP_RADD, 4'd0, 4'd0, 4'd15);
    do_scan("wrap_sum", 2'b10, 16'd14, 1'b1, 1'b0, 17);
    do_scan("wrap_min", 2'b00, 16'd0, 1'b1, 1'b0, 2);
    do_scan("wrap_max", 2'b01, 16'd1, 1'b1, 1'b0, 16);
    // Values become 5 then -9 for fifteen entries: 5 - 135 = -130.
    do_cmd("write_zero", OP_WRITE, 4'd0, 4'd0, 4'd5, 1'b0);
    do_scan("neg_sum", 2'b10, 16'hFF7E, 1'b1, 1'b0, 17);

    do_cmd("abort_clear", OP_CLEAR, 4'd0, 4'd0, 4'd0, 1'b0);
    do_cmd("abort_radd", OP_RADD, 4'd2, 4'd5, 4'd3, 1'b0);
    apply_stimulus(OP_SCAN, 4'd0, 4'd0, 4'd2);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_output("abort_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check_output("abort_busy", 32'(bus.busy), 32'd0);
    seen_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.result_valid) seen_valid = 1'b1;
      @(negedge clk);
    end
    check_output("abort_no_valid", 32'(seen_valid), 32'd0);
    do_scan("abort_sum", 2'b10, 16'd0, 1'b1, 1'b0, 17);

`ifdef DMADD_PEAK_EN
    do_cmd("peak_clear", OP_CLEAR, 4'd0, 4'd0, 4'd0, 1'b0);
    do_cmd("peak_radd_a", OP_RADD, 4'd2, 4'd5, 4'd3, 1'b0);
    do_cmd("peak_radd_b", OP_RADD, 4'd4, 4'd8, 4'd2, 1'b0);
    do_scan("peak", 2'b11, 16'd84, 1'b1, 1'b0, 17);
`else
    do_cmd("peak_clear", OP_CLEAR, 4'd0, 4'd0, 4'd0, 1'b0);
    do_cmd("peak_radd", OP_RADD, 4'd2, 4'd5, 4'd3, 1'b0);
    do_scan("peak_off", 2'b11, 16'd0, 1'b0, 1'b1, 1);
    do_scan("peak_off_sum", 2'b10, 16'd12, 1'b1, 1'b1, 17);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
